// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants, FSM encoding and address helper for the register file
package rf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] REG_SP   = 5'd2;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [RF_ADDR_W-1:0] REG_LAST = 5'd31;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

  // Only the low five bits select a register; upper bits alias freely.
  function automatic logic [RF_ADDR_W-1:0] rf_idx(input logic [31:0] addr);
    return addr[RF_ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - post-reset clear sweep sequencer and ready flag
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter logic [31:0] SP_INIT = 32'h0000_7FFC
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 rf_ready,
  output logic                 clr_we,
  output logic [RF_ADDR_W-1:0] clr_idx,
  output logic [31:0]          clr_data
);

  rf_state_e              state_q, state_d;
  logic [RF_ADDR_W-1:0]   clr_idx_q, clr_idx_d;

  // State and sweep-index registers; reset restarts the sweep from index 0.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_idx_q <= REG_ZERO;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Sweep one register per cycle, leave for RUN after the last index.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    clr_data  = 32'h0;
    if (state_q == CLEAR) begin
      // No storage writes while reset is asserted: reset alone leaves contents alone.
      clr_we    = reset_n;
      clr_data  = (clr_idx_q == REG_SP) ? SP_INIT : 32'h0;
      clr_idx_d = clr_idx_q + 5'd1;
      if (clr_idx_q == REG_LAST) begin
        state_d = RUN;
      end
    end
  end

  assign clr_idx  = clr_idx_q;
  assign rf_ready = (state_q == RUN);

endmodule

// File: rtl/reg_file_responder.sv
// rtl/reg_file_responder.sv - 32x32 register file with dual bypassed reads and cleared start-up
module reg_file_responder
  import rf_pkg::*;
#(
  parameter logic [31:0] SP_INIT  = 32'h0000_7FFC,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] load_pc_reg_addr1,
  input  logic [31:0] load_pc_reg_addr2,
  output logic [31:0] load_pc_reg_value1,
  output logic [31:0] load_pc_reg_value2,
  input  logic        op_write,
  input  logic [31:0] write_pc_reg_addr,
  input  logic [31:0] write_pc_reg_value,
  output logic        rf_ready,
  output logic        write_drop
);

  logic [31:0]          mem_q [NUM_REGS];
  logic                 clr_we;
  logic [RF_ADDR_W-1:0] clr_idx;
  logic [31:0]          clr_data;
  logic                 write_drop_q, write_drop_d;
  logic [RF_ADDR_W-1:0] raddr1, raddr2, waddr;
  logic                 user_we;

  // Upper address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, load_pc_reg_addr1[31:5],
                              load_pc_reg_addr2[31:5], write_pc_reg_addr[31:5]};

  assign raddr1 = rf_idx(load_pc_reg_addr1);
  assign raddr2 = rf_idx(load_pc_reg_addr2);
  assign waddr  = rf_idx(write_pc_reg_addr);

  rf_clear_seq #(
    .SP_INIT (SP_INIT)
  ) u_clear_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .rf_ready (rf_ready),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx),
    .clr_data (clr_data)
  );

  // User writes need a ready file and a nonzero target; x0 is never stored to.
  assign user_we = reset_n && op_write && rf_ready && (waddr != REG_ZERO);

  // Storage: the sweep has priority, user writes only land in RUN.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= clr_data;
    end else if (user_we) begin
      mem_q[waddr] <= write_pc_reg_value;
    end
  end

  // Sticky flag for any write attempted before the file was ready.
  always_comb begin
    write_drop_d = write_drop_q;
    if (op_write && !rf_ready) begin
      write_drop_d = 1'b1;
    end
  end

  // Drop flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      write_drop_q <= 1'b0;
    end else begin
      write_drop_q <= write_drop_d;
    end
  end

  assign write_drop = write_drop_q;

  // Read port 1: zero when not ready or x0, bypass on a same-cycle write hit.
  always_comb begin
    load_pc_reg_value1 = 32'h0;
    if (rf_ready && (raddr1 != REG_ZERO)) begin
      if (op_write && (waddr == raddr1)) begin
        load_pc_reg_value1 = write_pc_reg_value;
      end else begin
        load_pc_reg_value1 = mem_q[raddr1];
      end
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    load_pc_reg_value2 = 32'h0;
    if (rf_ready && (raddr2 != REG_ZERO)) begin
      if (op_write && (waddr == raddr2)) begin
        load_pc_reg_value2 = write_pc_reg_value;
      end else begin
        load_pc_reg_value2 = mem_q[raddr2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_responder.sv
// tb/tb_reg_file_responder.sv - directed table-driven bench for reg_file_responder
module tb_reg_file_responder;

  logic        clk;
  logic        reset_n;
  logic [31:0] addr1, addr2, waddr, wdata;
  logic        op_write;
  logic [31:0] val1, val2;
  logic        rf_ready, write_drop;

  int n_vec;
  int n_fail;

  localparam logic [31:0] SP = 32'h0000_7FFC;

  reg_file_responder #(
    .SP_INIT  (SP),
    .NUM_REGS (32)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .load_pc_reg_addr1  (addr1),
    .load_pc_reg_addr2  (addr2),
    .load_pc_reg_value1 (val1),
    .load_pc_reg_value2 (val2),
    .op_write           (op_write),
    .write_pc_reg_addr  (waddr),
    .write_pc_reg_value (wdata),
    .rf_ready           (rf_ready),
    .write_drop         (write_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until rf_ready is seen; 0 means the bound expired.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (rf_ready) begin
        cycles = c;
        break;
      end
    end
  endtask

  vec_t vecs[13];
  int   cyc;

  initial begin
    n_vec = 0;
    n_fail = 0;
    vecs[0]  = '{1'b0, 32'd0,          32'h0,         32'd2,  32'd5,  SP,            32'h0};
    vecs[1]  = '{1'b1, 32'd7,          32'hDEAD_BEEF, 32'd7,  32'd0,  32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 32'd0,          32'h0,         32'd7,  32'd2,  32'hDEAD_BEEF, SP};
    vecs[3]  = '{1'b1, 32'd0,          32'h1234,      32'd0,  32'd0,  32'h0,         32'h0};
    vecs[4]  = '{1'b0, 32'd0,          32'h0,         32'd0,  32'd0,  32'h0,         32'h0};
    vecs[5]  = '{1'b1, 32'd9,          32'h55AA,      32'd9,  32'd9,  32'h55AA,      32'h55AA};
    vecs[6]  = '{1'b0, 32'd0,          32'h0,         32'd9,  32'd7,  32'h55AA,      32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 32'hFFFF_FFE7,  32'h1111,      32'd7,  32'h27, 32'h1111,      32'h1111};
    vecs[8]  = '{1'b0, 32'd0,          32'h0,         32'd7,  32'd3,  32'h1111,      32'h0};
    vecs[9]  = '{1'b1, 32'd3,          32'hABCD,      32'd3,  32'd4,  32'hABCD,      32'h0};
    vecs[10] = '{1'b0, 32'd0,          32'h0,         32'd3,  32'd31, 32'hABCD,      32'h0};
    vecs[11] = '{1'b1, 32'd31,         32'hFFFF_FFFF, 32'd30, 32'd31, 32'h0,         32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 32'd0,          32'h0,         32'd31, 32'h22, 32'hFFFF_FFFF, SP};

    reset_n = 1'b0; op_write = 1'b0; waddr = 0; wdata = 0; addr1 = 32'd2; addr2 = 32'd9;
    repeat (3) step();
    check("reset_value1", val1, 32'h0);
    check("reset_value2", val2, 32'h0);
    check("reset_ready", {31'h0, rf_ready}, 32'h0);
    check("reset_drop", {31'h0, write_drop}, 32'h0);

    // First sweep with a write attempt before edge 10.
    reset_n = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      op_write = (c == 10);
      waddr    = 32'd3;
      wdata    = 32'hCAFE_0003;
      @(posedge clk);
      #1;
      op_write = 1'b0;
      if (c == 5) check("sweep_read_zero", val1, 32'h0);
      if (c == 10) check("drop_set", {31'h0, write_drop}, 32'h1);
      if (rf_ready) begin
        cyc = c;
        break;
      end
    end
    check("sweep_latency", cyc, 32);
    check("drop_sticky", {31'h0, write_drop}, 32'h1);

    for (int i = 0; i < 13; i++) begin
      op_write = vecs[i].we;
      waddr    = vecs[i].wa;
      wdata    = vecs[i].wd;
      addr1    = vecs[i].a1;
      addr2    = vecs[i].a2;
      #1;
      check($sformatf("vec%0d_value1", i), val1, vecs[i].e1);
      check($sformatf("vec%0d_value2", i), val2, vecs[i].e2);
      step();
    end
    op_write = 1'b0;
    check("drop_still_set", {31'h0, write_drop}, 32'h1);

    // Reset from RUN: ready drops on that edge, flag clears.
    reset_n = 1'b0;
    step();
    check("run_reset_ready", {31'h0, rf_ready}, 32'h0);
    check("run_reset_drop", {31'h0, write_drop}, 32'h0);
    step();

    // Release, then reset again mid-sweep at cycle 20.
    reset_n = 1'b1;
    repeat (20) step();
    check("mid_sweep_not_ready", {31'h0, rf_ready}, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;

    // Write in the cycle rf_ready rises must be dropped.
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      op_write = (c == 32);
      waddr    = 32'd5;
      wdata    = 32'h0000_0077;
      @(posedge clk);
      #1;
      op_write = 1'b0;
      if (rf_ready) begin
        cyc = c;
        break;
      end
    end
    check("resweep_latency", cyc, 32);
    check("edge_write_drop", {31'h0, write_drop}, 32'h1);
    addr1 = 32'h0000_0022;
    addr2 = 32'd5;
    #1;
    check("alias_sp", val1, SP);
    check("edge_write_lost", val2, 32'h0);
    addr1 = 32'd7;
    addr2 = 32'd31;
    #1;
    check("resweep_x7", val1, 32'h0);
    check("resweep_x31", val2, 32'h0);

    // Sanity: ready stays up in RUN.
    wait_ready(cyc);
    check("ready_holds", cyc, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
